// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter
// Shares the single registered read port of the on-chip sprite RAM between
// NUM_REQ tower draw units. Requests are arbitrated round-robin. The granted
// (x,y) coordinate is turned into a linear RAM address. The RAM's one-cycle
// registered read is absorbed by a second pipeline stage. The block returns a
// tagged pixel together with a transparency flag.
//
// Ports
//   Clk, Reset        clock; synchronous active-high reset
//   frame_start       1-cycle pulse; flushes the pipeline and the RR pointer
//   req/req_x/req_y   per-requester request and packed coordinates
//   gnt               one-hot combinational grant in the request cycle
//   mem_read_address  registered address to the sprite RAM
//   mem_data          registered read data from the sprite RAM
//   rd_valid/rd_id    response valid and requester index (grant + 2 cycles)
//   rd_pixel          pixel, KEY_COLOR for out-of-range coordinates
//   rd_transparent    pixel is KEY_COLOR or coordinate was out of range
module sprite_fetch_arbiter #(
  parameter int                NUM_REQ     = 4,
  parameter int                ID_W        = 2,
  parameter int                COORD_W     = 6,
  parameter int                SPRITE_W    = 50,
  parameter int                SPRITE_H    = 50,
  parameter int                SPRITE_BASE = 0,
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 24,
  parameter logic [DATA_W-1:0] KEY_COLOR   = '0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_start,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [ADDR_W-1:0]          mem_read_address,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       rd_valid,
  output logic [ID_W-1:0]            rd_id,
  output logic [DATA_W-1:0]          rd_pixel,
  output logic                       rd_transparent
);

  logic               clear;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    cand;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic               sel_oor;

  logic               vld_p1;
  logic [ID_W-1:0]    id_p1;
  logic               oor_p1;
  logic               vld_p2;
  logic [ID_W-1:0]    id_p2;
  logic               oor_p2;
  logic               out_en;

  // Linear sprite address; out-of-range coordinates read the sprite base.
  function automatic logic [ADDR_W-1:0] sprite_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y,
                                                    input logic              oor);
    if (oor) return ADDR_W'(SPRITE_BASE);
    return ADDR_W'(SPRITE_BASE) + ADDR_W'(y) * ADDR_W'(SPRITE_W) + ADDR_W'(x);
  endfunction

  // Reset and frame_start share one flush path.
  assign clear = Reset | frame_start;

  // S0: round-robin scan starting at ptr; the first hit wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
    if (clear) gnt_any = 1'b0;
  end

  assign gnt     = gnt_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_id) : '0;
  assign sel_x   = req_x[int'(gnt_id)*COORD_W +: COORD_W];
  assign sel_y   = req_y[int'(gnt_id)*COORD_W +: COORD_W];
  assign sel_oor = (32'(sel_x) >= SPRITE_W) || (32'(sel_y) >= SPRITE_H);

  // S0 -> S1 -> S2 control. The address and ids are cleared as well, so the
  // RAM port and rd_id read back as zero after a flush.
  always_ff @(posedge Clk) begin
    if (clear) begin
      ptr              <= '0;
      vld_p1           <= 1'b0;
      vld_p2           <= 1'b0;
      id_p1            <= '0;
      id_p2            <= '0;
      mem_read_address <= '0;
    end else begin
      vld_p1 <= gnt_any;
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
      if (gnt_any) begin
        ptr              <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
        id_p1            <= gnt_id;
        mem_read_address <= sprite_addr(sel_x, sel_y, sel_oor);
      end
    end
  end

  // S0 -> S1 -> S2 data; validity is carried by vld_p1/vld_p2.
  always_ff @(posedge Clk) begin
    if (gnt_any) oor_p1 <= sel_oor;
    oor_p2 <= oor_p1;
  end

  // S2: RAM data is aligned with the stage-2 tags. A flush cycle also hides
  // the response that was about to leave.
  assign out_en         = vld_p2 & ~clear;
  assign rd_valid       = out_en;
  assign rd_id          = clear ? '0 : id_p2;
  assign rd_pixel       = out_en ? (oor_p2 ? KEY_COLOR : mem_data) : '0;
  assign rd_transparent = out_en & (oor_p2 | (mem_data == KEY_COLOR));

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
module tb_sprite_fetch_arbiter;

  localparam int NV = 33;
  localparam logic [23:0] P = 24'h12AB34;
  localparam logic [23:0] Q = 24'hA00001;
  localparam logic [23:0] K = 24'h000000;
  // Requester coordinates: r0=(3,2) r1=(1,0) r2=(50,0) r3=(0,0)
  localparam logic [23:0] XA = {6'd0, 6'd50, 6'd1, 6'd3};
  localparam logic [23:0] YA = {6'd0, 6'd0, 6'd0, 6'd2};

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [3:0]  req;
  logic [23:0] req_x;
  logic [23:0] req_y;
  logic [3:0]  gnt;
  logic [18:0] mem_read_address;
  logic [23:0] mem_data;
  logic        rd_valid;
  logic [1:0]  rd_id;
  logic [23:0] rd_pixel;
  logic        rd_transparent;

  logic [23:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        fs;
    logic [3:0]  req;
    logic [3:0]  e_gnt;
    logic        e_vld;
    logic [1:0]  e_id;
    logic [23:0] e_pix;
    logic        e_tr;
    logic [18:0] e_addr;
  } vec_t;

  vec_t v [NV];

  sprite_fetch_arbiter dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .frame_start      (frame_start),
    .req              (req),
    .req_x            (req_x),
    .req_y            (req_y),
    .gnt              (gnt),
    .mem_read_address (mem_read_address),
    .mem_data         (mem_data),
    .rd_valid         (rd_valid),
    .rd_id            (rd_id),
    .rd_pixel         (rd_pixel),
    .rd_transparent   (rd_transparent)
  );

  always #5 Clk = ~Clk;

  // Sprite RAM with one-cycle registered read.
  always @(posedge Clk)
    mem_data <= (mem_read_address < 19'd4096) ? mem[mem_read_address[11:0]] : 24'hBADBAD;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  initial begin
    int lat;
    logic seen;
    logic [1:0]  got_id;
    logic [23:0] got_pix;
    logic        got_tr;

    for (int a = 0; a < 4096; a++) mem[a] = 24'hA00000 | 24'(a);
    mem[0]   = K;
    mem[103] = P;

    //        rst   fs    req    gnt    vld   id     pix  tr    addr
    v[0]  = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[1]  = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[2]  = '{1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[3]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[4]  = '{1'b0, 1'b0, 4'hF, 4'h1, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[5]  = '{1'b0, 1'b0, 4'hF, 4'h2, 1'b0, 2'd0, K, 1'b0, 19'd103};
    v[6]  = '{1'b0, 1'b0, 4'hF, 4'h4, 1'b1, 2'd0, P, 1'b0, 19'd1};
    v[7]  = '{1'b0, 1'b0, 4'hF, 4'h8, 1'b1, 2'd1, Q, 1'b0, 19'd0};
    v[8]  = '{1'b0, 1'b0, 4'hF, 4'h1, 1'b1, 2'd2, K, 1'b1, 19'd0};
    v[9]  = '{1'b0, 1'b0, 4'hF, 4'h2, 1'b1, 2'd3, K, 1'b1, 19'd103};
    v[10] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0, P, 1'b0, 19'd1};
    v[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1, Q, 1'b0, 19'd1};
    v[12] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd1};
    v[13] = '{1'b0, 1'b0, 4'h1, 4'h1, 1'b0, 2'd0, K, 1'b0, 19'd1};
    v[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd103};
    v[15] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0, P, 1'b0, 19'd103};
    v[16] = '{1'b0, 1'b0, 4'h4, 4'h4, 1'b0, 2'd0, K, 1'b0, 19'd103};
    v[17] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[18] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd2, K, 1'b1, 19'd0};
    v[19] = '{1'b0, 1'b0, 4'h8, 4'h8, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[20] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[21] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd3, K, 1'b1, 19'd0};
    v[22] = '{1'b0, 1'b0, 4'h2, 4'h2, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[23] = '{1'b0, 1'b0, 4'h4, 4'h4, 1'b0, 2'd0, K, 1'b0, 19'd1};
    v[24] = '{1'b0, 1'b1, 4'h6, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[25] = '{1'b0, 1'b0, 4'h6, 4'h2, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[26] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd1};
    v[27] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd1, Q, 1'b0, 19'd1};
    v[28] = '{1'b0, 1'b0, 4'h1, 4'h1, 1'b0, 2'd0, K, 1'b0, 19'd1};
    v[29] = '{1'b0, 1'b1, 4'h3, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd103};
    v[30] = '{1'b0, 1'b0, 4'h3, 4'h1, 1'b0, 2'd0, K, 1'b0, 19'd0};
    v[31] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0, K, 1'b0, 19'd103};
    v[32] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 2'd0, P, 1'b0, 19'd103};

    req_x = XA;
    req_y = YA;
    for (int i = 0; i < NV; i++) begin
      Reset       = v[i].rst;
      frame_start = v[i].fs;
      req         = v[i].req;
      @(negedge Clk);
      chk("gnt",   i, 32'(gnt),              32'(v[i].e_gnt));
      chk("valid", i, 32'(rd_valid),         32'(v[i].e_vld));
      chk("pixel", i, 32'(rd_pixel),         32'(v[i].e_pix));
      chk("transp",i, 32'(rd_transparent),   32'(v[i].e_tr));
      chk("addr",  i, 32'(mem_read_address), 32'(v[i].e_addr));
      if (v[i].e_vld || v[i].rst || v[i].fs)
        chk("id",  i, 32'(rd_id),            32'(v[i].e_id));
      @(posedge Clk);
      #1;
    end

    // Latency sequence: requester 2 at (10,1) -> address 60, pointer sits at 1.
    req_x = {6'd0, 6'd10, 6'd0, 6'd0};
    req_y = {6'd0, 6'd1, 6'd0, 6'd0};
    req   = 4'b0100;
    @(negedge Clk);
    chk("lat_gnt", 0, 32'(gnt), 32'h4);
    @(posedge Clk);
    #1;
    req     = 4'b0000;
    seen    = 1'b0;
    lat     = 0;
    got_id  = '0;
    got_pix = '0;
    got_tr  = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge Clk);
      if (k == 1) chk("lat_addr", k, 32'(mem_read_address), 32'd60);
      if (rd_valid && !seen) begin
        seen    = 1'b1;
        lat     = k;
        got_id  = rd_id;
        got_pix = rd_pixel;
        got_tr  = rd_transparent;
      end
    end
    chk("lat_seen",  0, 32'(seen),    32'd1);
    chk("lat_cyc",   0, 32'(lat),     32'd2);
    chk("lat_id",    0, 32'(got_id),  32'd2);
    chk("lat_pix",   0, 32'(got_pix), 32'hA0003C);
    chk("lat_tr",    0, 32'(got_tr),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
